// File: rtl/motor_pkg.sv
// Shared types, default constants and the demand clamp for the motor PWM path.
package motor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRamp,
    StRun,
    StBrake,
    StHold
  } motor_state_e;

  localparam int unsigned PWM_PERIOD_BITS = 9;
  localparam int unsigned PWM_PRESCALE    = 2;
  localparam int unsigned PWM_MAX_DUTY    = 480;
  localparam int unsigned PWM_RAMP_STEP   = 4;
  localparam int unsigned PWM_BRAKE_HOLD  = 8;

  // Negative demand maps to 0, anything above max_duty saturates. The result is
  // always non-negative, so callers may truncate it to their counter width.
  function automatic logic [9:0] clamp_demand(input logic signed [9:0] demand,
                                              input logic [9:0]        max_duty);
    logic [9:0] target;
    if (demand < 0) begin
      target = '0;
    end else if ($unsigned(demand) > max_duty) begin
      target = max_duty;
    end else begin
      target = $unsigned(demand);
    end
    return target;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// Prescaler plus free-running period counter; flags the last tick of each period.
module pwm_counter #(
  parameter int unsigned PERIOD_BITS = 9,
  parameter int unsigned PRESCALE    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PERIOD_BITS-1:0] cnt,
  output logic                   tick,
  output logic                   boundary
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PreW-1:0]        pre_q;
  logic [PERIOD_BITS-1:0] cnt_q;

  assign tick     = (pre_q == PreW'(PRESCALE - 1));
  assign boundary = tick && (cnt_q == '1);
  assign cnt      = cnt_q;

  // Prescaler wraps every PRESCALE clocks; the period counter advances once per tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      if (tick) begin
        pre_q <= '0;
        cnt_q <= cnt_q + PERIOD_BITS'(1);
      end else begin
        pre_q <= pre_q + PreW'(1);
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: clamp, soft-start slew, brake override with hold-off.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = PWM_PERIOD_BITS,
  parameter int unsigned PRESCALE    = PWM_PRESCALE,
  parameter int unsigned MAX_DUTY    = PWM_MAX_DUTY,
  parameter int unsigned RAMP_STEP   = PWM_RAMP_STEP,
  parameter int unsigned BRAKE_HOLD  = PWM_BRAKE_HOLD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [9:0]      demand,
  input  logic                   brake,
  output logic                   pwm_out,
  output logic [PERIOD_BITS-1:0] duty_applied,
  output logic                   ramping,
  output logic                   braking
);

  localparam int unsigned HoldW = $clog2(BRAKE_HOLD + 1);
  localparam logic [PERIOD_BITS:0] RampInc = (PERIOD_BITS + 1)'(RAMP_STEP);

  motor_state_e           state_q, state_d;
  logic [PERIOD_BITS-1:0] duty_q, duty_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   pwm_q, pwm_d;

  logic [PERIOD_BITS-1:0] cnt;
  logic                   tick;
  logic                   boundary;
  logic [PERIOD_BITS-1:0] target;
  logic [PERIOD_BITS:0]   step_sum;
  logic [PERIOD_BITS-1:0] step_duty;
  logic                   unused_tick;

  pwm_counter #(
    .PERIOD_BITS(PERIOD_BITS),
    .PRESCALE   (PRESCALE)
  ) u_pwm_counter (
    .clk     (clk),
    .reset   (reset),
    .cnt     (cnt),
    .tick    (tick),
    .boundary(boundary)
  );

  assign unused_tick = tick;
  assign target      = PERIOD_BITS'(clamp_demand(demand, 10'(MAX_DUTY)));

  // Next-state: brake overrides everything; otherwise duty moves only at a period boundary.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    hold_d    = hold_q;
    step_sum  = {1'b0, duty_q} + RampInc;
    step_duty = (step_sum >= {1'b0, target}) ? target : step_sum[PERIOD_BITS-1:0];

    if (brake) begin
      state_d = StBrake;
      duty_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (boundary && (target != '0)) begin
            state_d = StRamp;
            duty_d  = step_duty;
          end
        end
        StRamp, StRun: begin
          if (boundary) begin
            if (target > duty_q) begin
              // Rises are slew-limited; reaching the target ends the ramp.
              duty_d  = step_duty;
              state_d = (step_duty == target) ? StRun : StRamp;
            end else begin
              // Falls are applied in one step.
              duty_d  = target;
              state_d = (target == '0) ? StIdle : StRun;
            end
          end
        end
        StBrake: begin
          state_d = StHold;
          hold_d  = '0;
        end
        StHold: begin
          duty_d = '0;
          if (boundary) begin
            if (hold_q == HoldW'(BRAKE_HOLD - 1)) begin
              state_d = StIdle;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + HoldW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end

    pwm_d = (cnt < duty_q) && !brake && (state_q != StBrake) && (state_q != StHold);
  end

  // State, duty, hold counter and the registered PWM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      duty_q  <= '0;
      hold_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign duty_applied = duty_q;
  assign ramping      = (state_q == StRamp);
  assign braking      = (state_q == StBrake) || (state_q == StHold);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: table of per-period vectors plus brake/reset sequences.
module tb_motor_pwm_driver;

  localparam int PB    = 9;
  localparam int PS    = 2;
  localparam int MAXD  = 480;
  localparam int STEP  = 16;
  localparam int HOLD  = 8;
  localparam int PER   = (1 << PB) * PS;  // clk cycles per PWM period

  logic              clk = 1'b0;
  logic              reset;
  logic signed [9:0] demand;
  logic              brake;
  logic              pwm_out;
  logic [PB-1:0]     duty_applied;
  logic              ramping;
  logic              braking;

  int total = 0;
  int bad   = 0;
  int phase = 0;  // clk cycles since the last period wrap, tracked by the bench

  typedef struct {
    int dem;
    int periods;
    int exp_duty;
    int exp_ramp;
  } vec_t;

  vec_t vecs[13];

  motor_pwm_driver #(
    .PERIOD_BITS(PB),
    .PRESCALE   (PS),
    .MAX_DUTY   (MAXD),
    .RAMP_STEP  (STEP),
    .BRAKE_HOLD (HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .demand      (demand),
    .brake       (brake),
    .pwm_out     (pwm_out),
    .duty_applied(duty_applied),
    .ramping     (ramping),
    .braking     (braking)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      phase = (phase + 1) % PER;
    end
    #1;
  endtask

  task automatic to_boundary();
    step(PER - phase);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      step(1);
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    int hi;

    //            demand periods duty ramp
    vecs[0]  = '{-50,   2,     0,   0};
    vecs[1]  = '{100,   1,    16,   1};
    vecs[2]  = '{100,   5,    96,   1};
    vecs[3]  = '{100,   1,   100,   0};
    vecs[4]  = '{100,   1,   100,   0};
    vecs[5]  = '{ 40,   1,    40,   0};
    vecs[6]  = '{ 60,   1,    56,   1};
    vecs[7]  = '{ 60,   1,    60,   0};
    vecs[8]  = '{511,   1,    76,   1};
    vecs[9]  = '{511,  25,   476,   1};
    vecs[10] = '{511,   1,   480,   0};
    vecs[11] = '{511,   1,   480,   0};
    vecs[12] = '{300,   1,   300,   0};

    reset  = 1'b1;
    brake  = 1'b0;
    demand = '0;
    step(2);
    reset = 1'b0;
    phase = 0;

    check("reset duty", int'(duty_applied), 0);
    check("reset pwm", int'(pwm_out), 0);
    check("reset ramping", int'(ramping), 0);
    check("reset braking", int'(braking), 0);

    // Clamp and slew behaviour, one row per demand setting.
    for (int i = 0; i < 13; i++) begin
      demand = 10'(vecs[i].dem);
      for (int p = 0; p < vecs[i].periods; p++) to_boundary();
      check($sformatf("vec%0d duty", i), int'(duty_applied), vecs[i].exp_duty);
      check($sformatf("vec%0d ramping", i), int'(ramping), vecs[i].exp_ramp);
      check($sformatf("vec%0d braking", i), int'(braking), 0);
    end

    // Pulse width at duty 300: 300 ticks of PS clocks each.
    count_pwm(PER, hi);
    check("high clks at duty 300", hi, 300 * PS);

    // Brake during the high phase, release, full hold-off, ramp restart.
    step(50);
    check("pwm before brake", int'(pwm_out), 1);
    brake = 1'b1;
    step(1);
    check("brake pwm", int'(pwm_out), 0);
    check("brake duty", int'(duty_applied), 0);
    check("brake braking", int'(braking), 1);
    check("brake ramping", int'(ramping), 0);
    step(100);
    check("brake held pwm", int'(pwm_out), 0);
    brake = 1'b0;
    step(1);
    check("hold braking", int'(braking), 1);
    for (int b = 0; b < HOLD - 1; b++) begin
      to_boundary();
      check($sformatf("hold%0d braking", b), int'(braking), 1);
      check($sformatf("hold%0d duty", b), int'(duty_applied), 0);
    end
    to_boundary();
    check("hold end braking", int'(braking), 0);
    check("hold end duty", int'(duty_applied), 0);
    to_boundary();
    check("restart duty", int'(duty_applied), STEP);
    check("restart ramping", int'(ramping), 1);

    // Brake pulse mid-hold restarts the full hold-off.
    brake = 1'b1;
    step(1);
    check("brake2 duty", int'(duty_applied), 0);
    brake = 1'b0;
    step(1);
    for (int b = 0; b < 5; b++) to_boundary();
    step(10);
    brake = 1'b1;
    step(1);
    brake = 1'b0;
    step(1);
    for (int b = 0; b < HOLD - 1; b++) begin
      to_boundary();
      check($sformatf("rehold%0d braking", b), int'(braking), 1);
    end
    to_boundary();
    check("rehold end braking", int'(braking), 0);

    // Reset mid-ramp with the counter mid-period.
    for (int b = 0; b < 3; b++) to_boundary();
    check("preset duty", int'(duty_applied), 3 * STEP);
    check("preset ramping", int'(ramping), 1);
    step(600);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    phase = 0;
    check("midreset duty", int'(duty_applied), 0);
    check("midreset pwm", int'(pwm_out), 0);
    check("midreset ramping", int'(ramping), 0);
    check("midreset braking", int'(braking), 0);
    step(PER - 1);
    check("pre-boundary duty", int'(duty_applied), 0);
    step(1);
    check("post-reset duty", int'(duty_applied), STEP);
    check("post-reset ramping", int'(ramping), 1);

    // Demand toggles every clk; only the boundary-cycle value (0) may be taken.
    hi = 0;
    for (int k = 0; k < PER; k++) begin
      demand = (phase == PER - 1) ? 10'sd0 : 10'($urandom_range(100, 500));
      step(1);
      hi += int'(pwm_out);
    end
    check("noisy demand high clks", hi, STEP * PS);
    check("noisy demand duty", int'(duty_applied), 0);
    check("noisy demand ramping", int'(ramping), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
